// File: rtl/processador_pkg.sv
// Shared definitions for the fetch-sequencing stage: opcode constants,
// FSM state encoding, default address width and small decode helpers.
package processador_pkg;

    localparam int ADDR_W_PADRAO = 10;

    localparam logic [5:0] OPC_ADD   = 6'b000000;
    localparam logic [5:0] OPC_IN    = 6'b011100;
    localparam logic [5:0] OPC_PAUSE = 6'b011101;
    localparam logic [5:0] OPC_END   = 6'b011111;

    typedef enum logic [1:0] {
        EXEC   = 2'b00,
        ESPERA = 2'b01,
        FIM    = 2'b10
    } estado_t;

    // Conditional-branch decision: beq takes on zero, bne/blt on non-zero.
    function automatic logic desvio_tomado(
        input logic branch_control,
        input logic branch_tipo,
        input logic zero
    );
        return branch_control & (branch_tipo ? ~zero : zero);
    endfunction

endpackage

// File: rtl/contador_de_programa_if.sv
// Bus between the decoder/operator side (master) and the program counter
// (slave): decoder controls, ULA zero flag, confirm button and the PC results.
interface contador_de_programa_if
    import processador_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_PADRAO
) ();

    logic [5:0]        opcode;
    logic              DesvioControl;
    logic              jumpControl;
    logic              branchControl;
    logic              branchTipo;
    logic              zero;
    logic              status;
    logic              confirma;
    logic [ADDR_W-1:0] imediato;
    logic [ADDR_W-1:0] regDesvio;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcLink;
    logic              commit;
    logic              esperando;
    logic              parado;

    modport master (
        output opcode, DesvioControl, jumpControl, branchControl, branchTipo,
               zero, status, confirma, imediato, regDesvio,
        input  pc, pcLink, commit, esperando, parado
    );

    modport slave (
        input  opcode, DesvioControl, jumpControl, branchControl, branchTipo,
               zero, status, confirma, imediato, regDesvio,
        output pc, pcLink, commit, esperando, parado
    );

endinterface

// File: rtl/sincronizador_borda.sv
// Brings the asynchronous confirm button into the clock domain and turns
// each press into a single-cycle pulse.
// Build option: DEBOUNCE_EN inserts a stability filter of DEBOUNCE_CICLOS
// cycles between the synchronizer and the edge detector.
module sincronizador_borda
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CICLOS = 16
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    logic sync_1_r;
    logic sync_2_r;
    logic nivel_s;
    logic nivel_ant_r;
    logic pulso_r;

    // Two-flop synchronizer for the raw button level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_1_r <= 1'b0;
            sync_2_r <= 1'b0;
        end else begin
            sync_1_r <= entrada;
            sync_2_r <= sync_1_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CONT_W = $clog2(DEBOUNCE_CICLOS + 1);

    logic [CONT_W-1:0] contador_r;
    logic              filtrado_r;

    // Filtered level only follows the synchronized level after it has
    // disagreed for DEBOUNCE_CICLOS consecutive cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            contador_r <= '0;
            filtrado_r <= 1'b0;
        end else if (sync_2_r == filtrado_r) begin
            contador_r <= '0;
        end else if (contador_r == CONT_W'(DEBOUNCE_CICLOS - 1)) begin
            filtrado_r <= sync_2_r;
            contador_r <= '0;
        end else begin
            contador_r <= contador_r + CONT_W'(1);
        end
    end

    assign nivel_s = filtrado_r;
`else
    assign nivel_s = sync_2_r;
`endif

    // Rising-edge detector; the pulse is registered so it is glitch-free.
    always_ff @(posedge clock) begin
        if (!reset) begin
            nivel_ant_r <= 1'b0;
            pulso_r     <= 1'b0;
        end else begin
            nivel_ant_r <= nivel_s;
            pulso_r     <= nivel_s & ~nivel_ant_r;
        end
    end

    assign pulso = pulso_r;

endmodule

// File: rtl/contador_de_programa.sv
// Next-PC / fetch-sequencing stage. Computes the next instruction address
// from the decoder's jump/branch controls and the ULA zero flag, stalls on
// in/pause until the operator confirms, and halts for good on END.
// Build option: DEBOUNCE_EN enables the confirm-button debounce filter.
module contador_de_programa
    import processador_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_PADRAO,
    parameter logic [ADDR_W-1:0] PC_INICIAL = {ADDR_W{1'b0}}
`ifdef DEBOUNCE_EN
    ,
    parameter int                DEBOUNCE_CICLOS = 16
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    contador_de_programa_if.slave  bus
);

    localparam logic [ADDR_W-1:0] UM = {{(ADDR_W-1){1'b0}}, 1'b1};

    estado_t           estado_r;
    estado_t           estado_prox_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_prox_s;
    logic [ADDR_W-1:0] pc_mais_um_s;
    logic              commit_s;
    logic              confirma_pulso_s;
    logic              tomado_s;

    sincronizador_borda
`ifdef DEBOUNCE_EN
    #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    )
`endif
    u_sincronizador (
        .clock   (clock),
        .reset   (reset),
        .entrada (bus.confirma),
        .pulso   (confirma_pulso_s)
    );

    // Sequential increment wraps naturally at 2^ADDR_W.
    assign pc_mais_um_s = pc_r + UM;
    assign tomado_s     = desvio_tomado(bus.branchControl, bus.branchTipo, bus.zero);

    // State and PC registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_r <= EXEC;
            pc_r     <= PC_INICIAL;
        end else begin
            estado_r <= estado_prox_s;
            pc_r     <= pc_prox_s;
        end
    end

    // Next-state decode: END beats a stall request; only reset leaves FIM.
    always_comb begin
        estado_prox_s = estado_r;
        case (estado_r)
            EXEC: begin
                if (bus.opcode == OPC_END) begin
                    estado_prox_s = FIM;
                end else if (bus.status) begin
                    estado_prox_s = ESPERA;
                end else begin
                    estado_prox_s = EXEC;
                end
            end
            ESPERA: begin
                if (confirma_pulso_s) begin
                    estado_prox_s = EXEC;
                end else begin
                    estado_prox_s = ESPERA;
                end
            end
            FIM: begin
                estado_prox_s = FIM;
            end
            default: begin
                // Unused encoding: recover into normal execution.
                estado_prox_s = EXEC;
            end
        endcase
    end

    // Retire strobe and next PC; jumps override branches, PC holds unless
    // the current instruction retires.
    always_comb begin
        commit_s  = 1'b0;
        pc_prox_s = pc_r;
        case (estado_r)
            EXEC: begin
                if (bus.opcode == OPC_END) begin
                    commit_s  = 1'b0;
                    pc_prox_s = pc_r;
                end else if (bus.status) begin
                    commit_s  = 1'b0;
                    pc_prox_s = pc_r;
                end else if (bus.DesvioControl) begin
                    commit_s  = 1'b1;
                    pc_prox_s = bus.jumpControl ? bus.regDesvio : bus.imediato;
                end else if (tomado_s) begin
                    commit_s  = 1'b1;
                    pc_prox_s = bus.imediato;
                end else begin
                    commit_s  = 1'b1;
                    pc_prox_s = pc_mais_um_s;
                end
            end
            ESPERA: begin
                if (confirma_pulso_s) begin
                    commit_s  = 1'b1;
                    pc_prox_s = pc_mais_um_s;
                end else begin
                    commit_s  = 1'b0;
                    pc_prox_s = pc_r;
                end
            end
            FIM: begin
                commit_s  = 1'b0;
                pc_prox_s = pc_r;
            end
            default: begin
                commit_s  = 1'b0;
                pc_prox_s = pc_r;
            end
        endcase
    end

    assign bus.pc        = pc_r;
    assign bus.pcLink    = pc_mais_um_s;
    assign bus.commit    = commit_s;
    assign bus.esperando = (estado_r == ESPERA);
    assign bus.parado    = (estado_r == FIM);

endmodule

// File: tb/tb_contador_de_programa.sv
// Scoreboard bench for contador_de_programa: stimulus pushes the expected
// outputs of each cycle, a negedge monitor pops and compares them.
module tb_contador_de_programa;
    import processador_pkg::*;

    localparam int AW = 10;
`ifdef DEBOUNCE_EN
    localparam int LAT = 18;
    localparam int LIB = 22;
`else
    localparam int LAT = 3;
    localparam int LIB = 4;
`endif

    typedef struct {
        logic [AW-1:0] pc;
        logic          commit;
        logic          esp;
        logic          par;
    } esperado_t;

    logic      clk;
    logic      rst;
    esperado_t fila[$];
    int        tests_run;
    int        tests_failed;

    contador_de_programa_if #(.ADDR_W(AW)) bus ();

    contador_de_programa #(
        .ADDR_W     (AW),
        .PC_INICIAL (10'd0)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [AW-1:0] atual, input logic [AW-1:0] exp);
        tests_run++;
        if (atual !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, exp, $time);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (fila.size() > 0) begin
            esperado_t e;
            logic [AW-1:0] link;
            e    = fila.pop_front();
            link = e.pc + 10'd1;
            chk("pc", bus.pc, e.pc);
            chk("pcLink", bus.pcLink, link);
            chk("commit", {9'd0, bus.commit}, {9'd0, e.commit});
            chk("esperando", {9'd0, bus.esperando}, {9'd0, e.esp});
            chk("parado", {9'd0, bus.parado}, {9'd0, e.par});
        end
    end

    task automatic ciclo(input logic [AW-1:0] p, input logic c, input logic e, input logic f);
        esperado_t x;
        x.pc = p; x.commit = c; x.esp = e; x.par = f;
        fila.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic limpa();
        bus.opcode        = OPC_ADD;
        bus.DesvioControl = 1'b0;
        bus.jumpControl   = 1'b0;
        bus.branchControl = 1'b0;
        bus.branchTipo    = 1'b0;
        bus.zero          = 1'b0;
        bus.status        = 1'b0;
        bus.imediato      = 10'd0;
        bus.regDesvio     = 10'd0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        bus.confirma = 1'b0;
        limpa();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Sequential fetch from reset.
        for (int i = 0; i < 5; i++) ciclo(AW'(i), 1'b1, 1'b0, 1'b0);

        // Jumps: immediate, register, jal link, branch ignored under jump.
        bus.DesvioControl = 1'b1; bus.jumpControl = 1'b0; bus.imediato = 10'd40;
        ciclo(10'd5, 1'b1, 1'b0, 1'b0);
        bus.jumpControl = 1'b1; bus.regDesvio = 10'd7;
        ciclo(10'd40, 1'b1, 1'b0, 1'b0);
        bus.jumpControl = 1'b0; bus.imediato = 10'd15;
        ciclo(10'd7, 1'b1, 1'b0, 1'b0);
        bus.jumpControl = 1'b1; bus.regDesvio = 10'd17;
        bus.branchControl = 1'b1; bus.zero = 1'b1; bus.imediato = 10'd99;
        ciclo(10'd15, 1'b1, 1'b0, 1'b0);

        // Branches: beq taken, bne not taken, bne taken, beq not taken.
        limpa();
        bus.branchControl = 1'b1; bus.branchTipo = 1'b0; bus.zero = 1'b1; bus.imediato = 10'd20;
        ciclo(10'd17, 1'b1, 1'b0, 1'b0);
        bus.branchTipo = 1'b1; bus.zero = 1'b1; bus.imediato = 10'd50;
        ciclo(10'd20, 1'b1, 1'b0, 1'b0);
        bus.branchTipo = 1'b1; bus.zero = 1'b0; bus.imediato = 10'd3;
        ciclo(10'd21, 1'b1, 1'b0, 1'b0);
        bus.branchTipo = 1'b0; bus.zero = 1'b0; bus.imediato = 10'd60;
        ciclo(10'd3, 1'b1, 1'b0, 1'b0);

        // Plain fetch with a confirm press that lands in EXEC (discarded).
        limpa();
        bus.confirma = 1'b1;
        ciclo(10'd4, 1'b1, 1'b0, 1'b0);
        ciclo(10'd5, 1'b1, 1'b0, 1'b0);
        bus.confirma = 1'b0;
        ciclo(10'd6, 1'b1, 1'b0, 1'b0);
        ciclo(10'd7, 1'b1, 1'b0, 1'b0);
        ciclo(10'd8, 1'b1, 1'b0, 1'b0);

        // Stall on in at pc=9 for 50 cycles, then one confirm.
        bus.opcode = OPC_IN; bus.status = 1'b1;
        ciclo(10'd9, 1'b0, 1'b0, 1'b0);
        repeat (49) ciclo(10'd9, 1'b0, 1'b1, 1'b0);
        bus.confirma = 1'b1;
        for (int i = 0; i < LAT; i++) ciclo(10'd9, 1'b0, 1'b1, 1'b0);
        ciclo(10'd9, 1'b1, 1'b1, 1'b0);

        // Second in with the button still held: needs release and re-press.
        ciclo(10'd10, 1'b0, 1'b0, 1'b0);
        repeat (10) ciclo(10'd10, 1'b0, 1'b1, 1'b0);
        bus.confirma = 1'b0;
        repeat (LIB) ciclo(10'd10, 1'b0, 1'b1, 1'b0);
        bus.confirma = 1'b1;
        for (int i = 0; i < LAT; i++) ciclo(10'd10, 1'b0, 1'b1, 1'b0);
        ciclo(10'd10, 1'b1, 1'b1, 1'b0);
        bus.confirma = 1'b0;

`ifdef DEBOUNCE_EN
        // Short glitch is filtered out; a long press confirms once.
        ciclo(10'd11, 1'b0, 1'b0, 1'b0);
        repeat (LIB) ciclo(10'd11, 1'b0, 1'b1, 1'b0);
        bus.confirma = 1'b1;
        repeat (5) ciclo(10'd11, 1'b0, 1'b1, 1'b0);
        bus.confirma = 1'b0;
        repeat (25) ciclo(10'd11, 1'b0, 1'b1, 1'b0);
        bus.confirma = 1'b1;
        for (int i = 0; i < LAT; i++) ciclo(10'd11, 1'b0, 1'b1, 1'b0);
        ciclo(10'd11, 1'b1, 1'b1, 1'b0);
        bus.confirma = 1'b0;
        limpa();
`else
        limpa();
        ciclo(10'd11, 1'b1, 1'b0, 1'b0);
`endif

        // END at pc=12: frozen regardless of confirm and jump requests.
        bus.opcode = OPC_END;
        ciclo(10'd12, 1'b0, 1'b0, 1'b0);
        bus.DesvioControl = 1'b1; bus.imediato = 10'd33;
        bus.confirma = 1'b1;
        repeat (LAT + 3) ciclo(10'd12, 1'b0, 1'b0, 1'b1);
        bus.confirma = 1'b0;
        repeat (LIB) ciclo(10'd12, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        ciclo(10'd12, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        limpa();

        // Back in EXEC at 0; jump to the top address and wrap.
        bus.DesvioControl = 1'b1; bus.imediato = 10'd1023;
        ciclo(10'd0, 1'b1, 1'b0, 1'b0);
        limpa();
        ciclo(10'd1023, 1'b1, 1'b0, 1'b0);
        ciclo(10'd0, 1'b1, 1'b0, 1'b0);

        // Every expectation must have been consumed by the monitor.
        @(posedge clk);
        #1;
        chk("fila_vazia", AW'(fila.size()), 10'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
